// File: rtl/intdecl_pkg.sv
// Shared definitions for the int-declaration generator: FSM states and the
// ASCII bytes the block inserts into the stream itself.
package intdecl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_KW0,
    S_KW1,
    S_KW2,
    S_KW3,
    S_ID,
    S_SEP0,
    S_SEP1,
    S_SEMI,
    S_DRAIN
  } state_e;

  localparam logic [7:0] CH_I     = 8'h69;  // "i"
  localparam logic [7:0] CH_N     = 8'h6e;  // "n"
  localparam logic [7:0] CH_T     = 8'h74;  // "t"
  localparam logic [7:0] CH_SP    = 8'h20;  // " "
  localparam logic [7:0] CH_COMMA = 8'h2c;  // ","
  localparam logic [7:0] CH_SEMI  = 8'h3b;  // ";"

  localparam logic [23:0] KW_INT = {CH_I, CH_N, CH_T};

  // Identifier length saturates here; only "exactly 3" matters.
  localparam logic [2:0] LEN_SAT = 3'd4;

endpackage

// File: rtl/intdecl_charclass.sv
// Identifier character classifier: letters and underscore anywhere,
// digits only after the first character.
module intdecl_charclass (
  input  logic [7:0] char,
  input  logic       first,
  output logic       legal
);

  logic is_alpha;
  logic is_digit;

  assign is_alpha = (char >= 8'h61 && char <= 8'h7a) ||   // a-z
                    (char >= 8'h41 && char <= 8'h5a) ||   // A-Z
                    (char == 8'h5f);                      // _
  assign is_digit = (char >= 8'h30 && char <= 8'h39);

  assign legal = is_alpha || (is_digit && !first);

endmodule

// File: rtl/intdecl_gen.sv
// Streams "int <id>[, <id>]*;" one byte per cycle; identifier bytes come in
// on a valid/ready port, keyword/separators/terminator are inserted here.
module intdecl_gen
  import intdecl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       id_valid,
  input  logic [7:0] id_char,
  input  logic       id_last,
  input  logic       id_final,
  output logic       id_ready,
  output logic       out_valid,
  output logic [7:0] out_char,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_char_q, out_char_d;
  logic        err_q, err_d;
  logic [23:0] sh_q, sh_d;
  logic [2:0]  len_q, len_d;

  logic        slot_free;
  logic        legal;
  logic        load;
  logic [7:0]  load_char;
  logic [23:0] sh_n;
  logic [2:0]  len_n;

  intdecl_charclass u_charclass (
    .char  (id_char),
    .first (len_q == 3'd0),
    .legal (legal)
  );

  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    out_char_d  = out_char_q;
    err_d       = err_q;
    sh_d        = sh_q;
    len_d       = len_q;
    id_ready    = 1'b0;
    load        = 1'b0;
    load_char   = 8'h00;
    sh_n        = sh_q;
    len_n       = len_q;

    unique case (state_q)
      // "i" is loaded straight from IDLE so it is visible the cycle after start.
      S_IDLE: if (start) begin
        err_d     = 1'b0;
        sh_d      = '0;
        len_d     = '0;
        load      = 1'b1;
        load_char = CH_I;
        state_d   = S_KW1;
      end
      S_KW0: if (slot_free) begin
        load = 1'b1; load_char = CH_I; state_d = S_KW1;
      end
      S_KW1: if (slot_free) begin
        load = 1'b1; load_char = CH_N; state_d = S_KW2;
      end
      S_KW2: if (slot_free) begin
        load = 1'b1; load_char = CH_T; state_d = S_KW3;
      end
      S_KW3: if (slot_free) begin
        load = 1'b1; load_char = CH_SP; state_d = S_ID;
      end
      S_ID: begin
        id_ready = slot_free;
        if (id_valid && slot_free) begin
          if (legal) begin
            load      = 1'b1;
            load_char = id_char;
            sh_n      = {sh_q[15:0], id_char};
            len_n     = (len_q == LEN_SAT) ? LEN_SAT : len_q + 3'd1;
          end else begin
            err_d = 1'b1;
          end
          if (id_last) begin
            // Empty identifier or the bare keyword "int" is illegal.
            if (len_n == 3'd0 || (len_n == 3'd3 && sh_n == KW_INT)) err_d = 1'b1;
            sh_d    = '0;
            len_d   = '0;
            state_d = id_final ? S_SEMI : S_SEP0;
          end else begin
            sh_d  = sh_n;
            len_d = len_n;
          end
        end
      end
      S_SEP0: if (slot_free) begin
        load = 1'b1; load_char = CH_COMMA; state_d = S_SEP1;
      end
      S_SEP1: if (slot_free) begin
        load = 1'b1; load_char = CH_SP; state_d = S_ID;
      end
      S_SEMI: if (slot_free) begin
        load = 1'b1; load_char = CH_SEMI; state_d = S_DRAIN;
      end
      S_DRAIN: if (slot_free) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_char_d  = load_char;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
      err_q       <= 1'b0;
      sh_q        <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      err_q       <= err_d;
      sh_q        <= sh_d;
      len_q       <= len_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule
